pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It watches the decode, execute and memory stages for load-use hazards, multi-cycle data-memory accesses and taken branches. It drives the write-enable, bubble, flush and hold controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. All enables are decoded combinationally from the registered state and the current inputs.

---
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, data-memory waits, branch flushes.
// Optional feature: define STALL_COUNT_EN to build the saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        startin,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        mem_access,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        pipe_hold,
    output logic        mem_error,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_error_q;
    logic        err_set;
    logic        load_use;
    logic        mem_stall;

    always_comb begin
        load_use     = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        mem_stall    = mem_access && !mem_ready;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;
        state_d      = RUN;
        wait_cnt_d   = wait_cnt_q;
        err_set      = 1'b0;
        case (state_q)
            MEM_WAIT: begin
                // Branches are ignored here; the frozen MEM stage re-presents them after exit.
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = RUN;
                    err_set = 1'b1;
                end else begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                if (mem_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = 16'd0;
                end else if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = FLUSH;
                end else if (load_use && (state_q == RUN)) begin
                    // LU_STALL and FLUSH mask detection: IF/ID is either already bubbled or invalid.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = LU_STALL;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge startin) begin
        if (startin) begin
            state_q     <= RUN;
            wait_cnt_q  <= 16'd0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_q | err_set;
        end
    end

    assign ctrl_state = state_q;
    assign mem_error  = mem_error_q;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock or posedge startin) begin
        if (startin) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        startin;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, mem_access, mem_ready, branch_taken;
    logic        pc_write, if_id_write, id_ex_bubble;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        pipe_hold, mem_error;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic [25:0] obs_vec;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .startin(startin),
        .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_access(mem_access), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .pipe_hold(pipe_hold), .mem_error(mem_error), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    assign obs_vec = {ctrl_state, pc_write, if_id_write, id_ex_bubble, if_id_flush,
                      id_ex_flush, ex_mem_flush, pipe_hold, mem_error, stall_cycles};

    int checks = 0;
    int errors = 0;

    // Model state: which phase the controller is in, hold cycles spent on the current
    // memory access (entry cycle included), sticky error and the total of stalled cycles.
    int          m_phase;
    int          m_held;
    bit          m_err;
    int          m_stall;
    int          n_phase, n_held;
    bit          n_err, e_pc;
    logic [25:0] exp_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_held = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic model_eval();
        bit lu, ifw, bub, fl, hold;
        logic [15:0] sc;
        lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        e_pc = 1; ifw = 1; bub = 0; fl = 0; hold = 0;
        n_phase = 0; n_held = m_held; n_err = 0;
        if (m_phase == 2) begin
            if (mem_ready) n_phase = 0;
            else if (m_held >= TO) n_err = 1;
            else begin e_pc = 0; ifw = 0; hold = 1; n_phase = 2; n_held = m_held + 1; end
        end else if (mem_access && !mem_ready) begin
            e_pc = 0; ifw = 0; hold = 1; n_phase = 2; n_held = 1;
        end else if (branch_taken) begin
            fl = 1; n_phase = 3;
        end else if (lu && m_phase == 0) begin
            e_pc = 0; ifw = 0; bub = 1; n_phase = 1;
        end
`ifdef STALL_COUNT_EN
        sc = 16'(m_stall);
`else
        sc = 16'd0;
`endif
        exp_vec = {2'(m_phase), e_pc, ifw, bub, fl, fl, fl, hold, m_err, sc};
    endtask

    task automatic model_commit();
        if (!e_pc && m_stall < 65535) m_stall++;
        m_err   = m_err | n_err;
        m_phase = n_phase;
        m_held  = n_held;
    endtask

    task automatic eval_chk(input string tag);
        #1;
        model_eval();
        chk(tag, 32'(obs_vec), 32'(exp_vec));
    endtask

    task automatic adv();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0;
        mem_access = 0; mem_ready = 0; branch_taken = 0;
    endtask

    initial begin
        int held;
        logic [15:0] s0;
        startin = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("reset_state_held", 32'(ctrl_state), 32'd0);
        startin = 1'b0;
        eval_chk("reset_defaults"); adv();

        // Load-use: one bubble, then LU_STALL masks the still-present pattern.
        ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        eval_chk("lu_detect");
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
        adv();
        eval_chk("lu_masked");
        chk("lu_state1", 32'(ctrl_state), 32'd1);
        chk("lu_masked_pc", 32'(pc_write), 32'd1);
        idle_inputs(); adv();
        eval_chk("lu_back");
        chk("lu_state0", 32'(ctrl_state), 32'd0);
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        eval_chk("lu_r0");
        chk("lu_r0_nostall", 32'(pc_write), 32'd1);
        idle_inputs(); adv();

        // Branch: three flushes, then one FLUSH cycle that ignores load-use.
        branch_taken = 1;
        eval_chk("br_flush");
        chk("br_flush_all", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'd7);
        adv();
        branch_taken = 0; ex_mem_read = 1; ex_rt = 3; id_rt = 3;
        eval_chk("br_masked");
        chk("br_state3", 32'(ctrl_state), 32'd3);
        chk("br_masked_bubble", 32'(id_ex_bubble), 32'd0);
        idle_inputs(); adv();
        eval_chk("br_back");
        chk("br_state0", 32'(ctrl_state), 32'd0);
        adv();

        // Memory wait: ready in the 4th cycle after entry -> 4 held cycles.
        s0 = stall_cycles;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            mem_access = 1; mem_ready = 0;
            eval_chk("mw_hold");
            held += int'(pipe_hold);
            adv();
        end
        mem_ready = 1;
        eval_chk("mw_ready");
        held += int'(pipe_hold);
        adv();
        idle_inputs();
        chk("mw_hold_len", 32'(held), 32'd4);
`ifdef STALL_COUNT_EN
        chk("mw_stall_cycles", 32'(stall_cycles - s0), 32'd4);
`endif
        mem_access = 1; mem_ready = 1;
        eval_chk("mw_entry_ready");
        chk("mw_entry_ready_nostall", 32'(pc_write), 32'd1);
        adv();
        idle_inputs();

        // Timeout: mem_ready never arrives.
        held = 0;
        mem_access = 1; mem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            eval_chk("to_wait");
            if (pipe_hold !== 1'b1) break;
            held++;
            adv();
        end
        chk("to_hold_len", 32'(held), 32'd8);
        adv();
        idle_inputs();
        eval_chk("to_after");
        chk("to_error_set", 32'(mem_error), 32'd1);
        chk("to_state_run", 32'(ctrl_state), 32'd0);
        for (int i = 0; i < 3; i++) begin adv(); eval_chk("to_sticky"); end
        chk("to_error_sticky", 32'(mem_error), 32'd1);

        // Asynchronous reset in the middle of a memory wait.
        mem_access = 1; mem_ready = 0;
        eval_chk("rst_enter"); adv();
        eval_chk("rst_wait"); adv();
        idle_inputs();
        startin = 1'b1;
        #1;
        model_reset();
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_mem_error", 32'(mem_error), 32'd0);
        mem_access = 1;
        #1;
        chk("rst_restall", 32'(pc_write), 32'd0);
        idle_inputs();
        @(negedge clock);
        startin = 1'b0;
        eval_chk("rst_released"); adv();

        // Memory wait, branch and load-use together: only the hold applies.
        mem_access = 1; mem_ready = 0; branch_taken = 1;
        ex_mem_read = 1; ex_rt = 7; id_rs = 7;
        eval_chk("sim_entry");
        chk("sim_only_hold", 32'({pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble}), 32'h10);
        adv();
        eval_chk("sim_wait"); adv();
        mem_ready = 1;
        eval_chk("sim_ready");
        chk("sim_ready_noflush", 32'(if_id_flush), 32'd0);
        adv();
        mem_access = 0; mem_ready = 0;
        eval_chk("sim_branch");
        chk("sim_branch_flush", 32'(ex_mem_flush), 32'd1);
        adv();
        idle_inputs();
        eval_chk("sim_flush_state"); adv();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            mem_access   = ($urandom_range(0, 3) == 0);
            mem_ready    = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 6) == 0);
            eval_chk("rand");
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
